// File: rtl/fpga_robots_game_tone.sv
// Multi-voice square/sine tone generator with a summing mixer and 1-bit sigma-delta output.
// Optional sine voices are built when FPGA_ROBOTS_TONE_SINE_EN is defined; otherwise all voices are square.
module fpga_robots_game_tone #(
    parameter int CHANNELS = 2,
    parameter int PHASE_W  = 16,
    parameter int DUR_W    = 12,
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int MIX_W   = 8 + $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                cmd_stb,
    input  logic [CHAN_W-1:0]   cmd_chan,
    input  logic [PHASE_W-1:0]  cmd_inc,
    input  logic [DUR_W-1:0]    cmd_dur,
    input  logic                cmd_mode,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done,
    output logic                audio
);

    logic [PHASE_W-1:0]  r_phase [CHANNELS];
    logic [PHASE_W-1:0]  r_inc   [CHANNELS];
    logic [DUR_W-1:0]    r_dur   [CHANNELS];
    logic [CHANNELS-1:0] r_busy;
    logic [CHANNELS-1:0] r_done;
    logic [7:0]          r_smp   [CHANNELS];
    logic [7:0]          w_smp   [CHANNELS];
    logic [MIX_W-1:0]    r_mix;
    logic [MIX_W-1:0]    w_mix;
    logic [MIX_W-1:0]    r_acc;
    logic                r_audio;

`ifdef FPGA_ROBOTS_TONE_SINE_EN
    logic [CHANNELS-1:0] r_mode;

    // Quarter-wave sine magnitudes, sampled at the centre of each of 64 steps.
    localparam logic [6:0] SINE_Q [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };
`else
    logic w_unused;
    assign w_unused = cmd_mode;
`endif

    // A command to a voice always beats a same-cycle tick on that voice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
            r_done <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_phase[c] <= '0;
                r_inc[c]   <= '0;
                r_dur[c]   <= '0;
`ifdef FPGA_ROBOTS_TONE_SINE_EN
                r_mode[c]  <= 1'b0;
`endif
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_done[c] <= 1'b0;
                if (cmd_stb && (cmd_chan == CHAN_W'(c))) begin
                    r_phase[c] <= '0;
                    r_dur[c]   <= cmd_dur;
                    r_busy[c]  <= (cmd_dur != '0);
                    if (cmd_dur != '0) begin
                        r_inc[c]  <= cmd_inc;
`ifdef FPGA_ROBOTS_TONE_SINE_EN
                        r_mode[c] <= cmd_mode;
`endif
                    end
                end else if (tick && r_busy[c]) begin
                    r_phase[c] <= r_phase[c] + r_inc[c];
                    r_dur[c]   <= r_dur[c] - DUR_W'(1);
                    if (r_dur[c] == DUR_W'(1)) begin
                        r_busy[c] <= 1'b0;
                        r_done[c] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        logic [5:0] w_k;
        w_k = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_smp[c] = 8'd0;
            if (r_busy[c]) begin
`ifdef FPGA_ROBOTS_TONE_SINE_EN
                if (r_mode[c]) begin
                    w_k = r_phase[c][PHASE_W-3 -: 6];
                    if (r_phase[c][PHASE_W-2]) w_k = ~w_k;
                    w_smp[c] = r_phase[c][PHASE_W-1] ? (8'd127 - {1'b0, SINE_Q[w_k]})
                                                     : (8'd128 + {1'b0, SINE_Q[w_k]});
                end else begin
                    w_smp[c] = {8{r_phase[c][PHASE_W-1]}};
                end
`else
                w_smp[c] = {8{r_phase[c][PHASE_W-1]}};
`endif
            end
        end
    end

    always_comb begin
        w_mix = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_mix = w_mix + MIX_W'(r_smp[c]);
        end
    end

    // The carry out of the accumulator is the 1-bit output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) r_smp[c] <= 8'd0;
            r_mix   <= '0;
            r_acc   <= '0;
            r_audio <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) r_smp[c] <= w_smp[c];
            r_mix <= w_mix;
            {r_audio, r_acc} <= {1'b0, r_acc} + {1'b0, r_mix};
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign audio = r_audio;

endmodule

// File: tb/tb_fpga_robots_game_tone.sv
// Bench for fpga_robots_game_tone: vector table, corner sequences and randomized traffic vs a voice model.
// Sample values are observed through the density of the sigma-delta output over 2^MIX_W clocks.
module tb_fpga_robots_game_tone;
    localparam int CHANNELS = 2;
    localparam int PHASE_W  = 16;
    localparam int DUR_W    = 12;
    localparam int MIX_W    = 9;
`ifdef FPGA_ROBOTS_TONE_SINE_EN
    localparam bit SINE_EN = 1'b1;
`else
    localparam bit SINE_EN = 1'b0;
`endif

    // Clock and reset
    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                tick = 1'b0;
    logic                cmd_stb = 1'b0;
    logic [0:0]          cmd_chan = '0;
    logic [PHASE_W-1:0]  cmd_inc = '0;
    logic [DUR_W-1:0]    cmd_dur = '0;
    logic                cmd_mode = 1'b0;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] done;
    logic                audio;

    always #5 clk = ~clk;

    fpga_robots_game_tone #(
        .CHANNELS(CHANNELS), .PHASE_W(PHASE_W), .DUR_W(DUR_W)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .cmd_stb(cmd_stb), .cmd_chan(cmd_chan),
        .cmd_inc(cmd_inc), .cmd_dur(cmd_dur), .cmd_mode(cmd_mode),
        .busy(busy), .done(done), .audio(audio)
    );

    // Scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    logic [MIX_W-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Voice model
    int m_phase[CHANNELS];
    int m_inc[CHANNELS];
    int m_dur[CHANNELS];
    bit m_busy[CHANNELS];
    bit m_done[CHANNELS];
    bit m_mode[CHANNELS];

    function automatic void model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_phase[c] = 0; m_inc[c] = 0; m_dur[c] = 0;
            m_busy[c] = 0; m_done[c] = 0; m_mode[c] = 0;
        end
    endfunction

    function automatic void model_step(bit stb, int chan, int inc, int dur, bit mode, bit tk);
        for (int c = 0; c < CHANNELS; c++) begin
            m_done[c] = 0;
            if (stb && chan == c) begin
                m_phase[c] = 0;
                m_dur[c]   = dur;
                m_busy[c]  = (dur != 0);
                if (dur != 0) begin
                    m_inc[c]  = inc;
                    m_mode[c] = mode;
                end
            end else if (tk && m_busy[c]) begin
                m_phase[c] = (m_phase[c] + m_inc[c]) % 65536;
                m_dur[c]   = m_dur[c] - 1;
                if (m_dur[c] == 0) begin
                    m_busy[c] = 0;
                    m_done[c] = 1;
                end
            end
        end
    endfunction

    function automatic int sample_of(int c);
        int pos, quarter, k, s;
        if (!m_busy[c]) return 0;
        pos = m_phase[c] / 256;
        quarter = pos / 64;
        if (SINE_EN && m_mode[c]) begin
            k = pos % 64;
            if (quarter % 2 == 1) k = 63 - k;
            s = $rtoi(127.0 * $sin(3.14159265358979 * (k + 0.5) / 128.0) + 0.5);
            return (quarter < 2) ? 128 + s : 127 - s;
        end
        return (quarter >= 2) ? 255 : 0;
    endfunction

    function automatic int model_mix();
        int sum = 0;
        for (int c = 0; c < CHANNELS; c++) sum += sample_of(c);
        return sum;
    endfunction

    // Driver tasks: entered and left at a falling edge.
    task automatic cycle(input bit stb, input int chan, input int inc, input int dur,
                         input bit mode, input bit tk);
        cmd_stb  = stb;
        cmd_chan = 1'(chan);
        cmd_inc  = PHASE_W'(inc);
        cmd_dur  = DUR_W'(dur);
        cmd_mode = mode;
        tick     = tk;
        @(posedge clk);
        model_step(stb, chan, inc, dur, mode, tk);
        @(negedge clk);
        for (int c = 0; c < CHANNELS; c++) begin
            check($sformatf("busy%0d", c), busy[c], m_busy[c]);
            check($sformatf("done%0d", c), done[c], m_done[c]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic stop_all();
        for (int c = 0; c < CHANNELS; c++) cycle(1, c, 0, 0, 0, 0);
    endtask

    task automatic density(input string name);
        int cnt = 0;
        idle(4);
        repeat (1 << MIX_W) begin
            @(negedge clk);
            cnt += audio;
        end
        check(name, cnt, exp_q.pop_front());
    endtask

    typedef struct {
        string name;
        int    inc;
        int    dur;
        int    ticks;
        bit    mode;
        bit    exp_busy;
        int    exp_smp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int dn;
        vecs[0] = '{"ph_0000", 'h4000, 100, 0, 1'b1, 1'b1, SINE_EN ? 130 : 0};
        vecs[1] = '{"ph_4000", 'h4000, 100, 1, 1'b1, 1'b1, SINE_EN ? 255 : 0};
        vecs[2] = '{"ph_8000", 'h4000, 100, 2, 1'b1, 1'b1, SINE_EN ? 125 : 255};
        vecs[3] = '{"ph_c000", 'h4000, 100, 3, 1'b1, 1'b1, SINE_EN ? 0 : 255};
        vecs[4] = '{"half",    'h8000, 10,  1, 1'b0, 1'b1, 255};
        vecs[5] = '{"expire",  'h8000, 3,   3, 1'b0, 1'b0, 0};
        vecs[6] = '{"odd7",    'h1234, 50,  7, 1'b0, 1'b1, 0};
        vecs[7] = '{"odd8",    'h1234, 50,  8, 1'b0, 1'b1, 255};
        vecs[8] = '{"stopped", 'h8000, 0,   2, 1'b0, 1'b0, 0};

        // Reset state
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_audio", audio, 0);
        rst = 1'b1;
        idle(2);

        // Vector table on voice 0
        foreach (vecs[i]) begin
            stop_all();
            cycle(1, 0, vecs[i].inc, vecs[i].dur, vecs[i].mode, 0);
            repeat (vecs[i].ticks) cycle(0, 0, 0, 0, 0, 1);
            check({vecs[i].name, "_busy"}, busy[0], vecs[i].exp_busy);
            exp_q.push_back(MIX_W'(vecs[i].exp_smp));
            density(vecs[i].name);
        end

        // Square expiry after exactly four back-to-back ticks
        stop_all();
        cycle(1, 0, 'h8000, 4, 0, 0);
        dn = 0;
        repeat (3) begin
            cycle(0, 0, 0, 0, 0, 1);
            dn += done[0];
        end
        check("exp_busy_pre", busy[0], 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("exp_busy_post", busy[0], 0);
        dn += done[0];
        repeat (3) begin
            cycle(0, 0, 0, 0, 0, 0);
            dn += done[0];
        end
        check("exp_done_count", dn, 1);

        // Stop command: no done pulse, sample drops to zero
        cycle(1, 1, 'h8000, 100, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        exp_q.push_back(MIX_W'(255));
        density("stop_before");
        cycle(1, 1, 0, 0, 0, 0);
        check("stop_busy", busy[1], 0);
        check("stop_done", done[1], 0);
        exp_q.push_back(MIX_W'(0));
        density("stop_after");

        // Collision: expiring tick and a restart in the same cycle
        stop_all();
        cycle(1, 0, 'h4000, 2, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, 'h8000, 5, 0, 1);
        check("coll_busy", busy[0], 1);
        check("coll_done", done[0], 0);
        exp_q.push_back(MIX_W'(0));
        density("coll_phase");
        dn = 0;
        repeat (4) begin
            cycle(0, 0, 0, 0, 0, 1);
            dn += done[0];
        end
        check("coll_dur_busy", busy[0], 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("coll_dur_done", done[0] + dn, 1);

        // Both voices at full square: density 510 of 512
        stop_all();
        cycle(1, 0, 'h8000, 10, 0, 0);
        cycle(1, 1, 'h8000, 10, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        exp_q.push_back(MIX_W'(510));
        density("mix_510");

        // Randomized traffic against the model
        stop_all();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, CHANNELS - 1),
                  $urandom_range(0, 65535), $urandom_range(0, 6),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        exp_q.push_back(MIX_W'(model_mix()));
        density("rand_mix");

        // Asynchronous reset mid-tone
        stop_all();
        cycle(1, 0, 'h8000, 200, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        idle(6);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_audio", audio, 0);
        @(negedge clk);
        repeat (3) begin
            cycle(0, 0, 0, 0, 0, 1);
            check("arst_hold_audio", audio, 0);
        end
        rst = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpga_robots_game_tone.md
# fpga_robots_game_tone

Parametrised multi-channel tone generator for the game's audio path. It replaces the fixed single-tone attention beeper with `CHANNELS` independent voices. Each voice has a programmable phase increment, a duration, and a square or sine waveform. It sits between game/control logic, which issues tone commands, and the `o_audio_l`/`o_audio_r` pins. It mixes all voices and drives a 1-bit sigma-delta output.

## Interface
Parameters:
- `CHANNELS`, 2: number of independent voices, ≥1.
- `PHASE_W`, 16: phase accumulator and increment width, ≥8.
- `DUR_W`, 12: duration counter width, in ticks.

Ports:
- `clk` in 1: system clock (~65 MHz).
- `rst` in 1: reset, asynchronous, active-low.
- `tick` in 1: one-cycle sample strobe (e.g. `baud8`); advances voices.
- `cmd_stb` in 1: command strobe; accepted on every cycle it is high. There is no backpressure.
- `cmd_chan` in `$clog2(CHANNELS)` (min 1): target voice.
- `cmd_inc` in `PHASE_W`: phase increment per tick.
- `cmd_dur` in `DUR_W`: duration in ticks; 0 = stop.
- `cmd_mode` in 1: 0 = square, 1 = sine.
- `busy` out `CHANNELS`: voice active.
- `done` out `CHANNELS`: one-cycle pulse when a voice expires naturally.
- `audio` out 1: sigma-delta output.

## Operation
Per-voice state: `phase`[PHASE_W], `inc`, `dur`[DUR_W], `mode`, `busy`.

Command accepted (`cmd_stb` high and `cmd_chan < CHANNELS`):
- `cmd_dur != 0`: load `inc`, `mode` and `dur = cmd_dur`; set `phase = 0` and `busy = 1`. This restarts the voice if it is already active.
- `cmd_dur == 0`: set `busy = 0`, `dur = 0`, `phase = 0`. No `done` pulse.
- `cmd_chan >= CHANNELS`: command ignored.

On `tick`, for each busy voice not addressed by a command in the same cycle:
- `phase += inc`, modulo 2^PHASE_W (wraps silently).
- `dur -= 1`. If `dur` was 1, then `busy <= 0` and `done[ch] <= 1` for one cycle.

Simultaneous events:
- A command and an expiry on the same voice in the same cycle: the command wins; no `done` pulse.
- Commands to one voice never disturb other voices.

Sample generation, 8-bit unsigned per voice:
- Idle voice: 0.
- Square: 255 if `phase[PHASE_W-1]` is 1, else 0.
- Sine (see Configuration): quarter-wave table `s(k) = round(127·sin(π/2·(k+0.5)/64))` for k = 0..63.
  - Index: `k = phase[PHASE_W-3 -: 6]` if `phase[PHASE_W-2]` is 0, else `63 - k`.
  - Sample: `128 + s(k)` if `phase[PHASE_W-1]` is 0, else `127 - s(k)`.

Mix and output:
- `MIX_W = 8 + $clog2(CHANNELS)`. `mix` = sum of all voice samples, no saturation needed.
- Sigma-delta: `{audio, acc} <= acc + mix` every clk, with `acc` being `MIX_W` bits.
- Long-run density of `audio` = `mix / 2^MIX_W`.

## Timing
- Reset values: `busy` = 0, `done` = 0, `audio` = 0; all `phase`/`dur`/`inc`/`mode` = 0; `mix` = 0, `acc` = 0. Reset takes effect immediately, mid-tone included.
- Command to `busy` change: 1 clk (registered).
- Expiring tick to `done` pulse: 1 clk. `done` lasts exactly one clk.
- Pipeline: phase register → sample register (+1 clk) → `mix` register (+1 clk) → `audio` (+1 clk). A phase change reaches the `audio` computation 3 clk later.
- `tick` may be high on consecutive cycles; each high cycle is a separate advance.

## Configuration
- `FPGA_ROBOTS_TONE_SINE_EN` defined: sine table and `mode` storage are built; `cmd_mode` selects the waveform.
- Not defined: `cmd_mode` is ignored, no table is synthesised, and all voices are square.
  - Everything else is identical, including port list and `done`/`busy` behaviour.

## Test plan
- Async reset mid-tone: voice 0 busy, `rst` driven low between clock edges → `busy`, `done`, `audio` all 0 before the next edge; stay 0 while `rst` is low.
- Square expiry: ch0 `inc=0x8000`, `dur=4`, then 4 ticks → phase sequence 0x8000, 0, 0x8000, 0. `busy[0]` is high across all 4 ticks, goes low 1 clk after the 4th tick, together with a single 1-clk `done[0]` pulse.
- Stop: ch1 active with `dur=100`, then command `dur=0` → `busy[1]` low next clk, no `done[1]` pulse, sample 0.
- Collision: ch0 at `dur=1`; `tick` and a new command (`dur=5`) in the same cycle → `busy[0]` stays 1, no `done[0]`, `phase=0`, `dur=5`.
- Sigma-delta density (CHANNELS=2): both voices `inc=0x8000`, `dur=10`, one tick, then no ticks → `mix=510`; count of `audio` highs over the next 512 clk = 510 (±1).
- Sine (macro defined): `inc=0x4000`, `mode=1`:
  - Phase 0 → sample 130.
  - Phase 0x4000 → sample 255.
  - Phase 0xC000 → sample 0.
  - Same stimulus with the macro undefined → samples 0, 0, 255.
